// File: rtl/risc_misr_compactor_if.sv
// Handshake bundle between the RISC result bus and the MISR compactor.
// The slave side belongs to the compactor; the master side drives it.
interface risc_misr_compactor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             data_valid;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [15:0]      word_count;

  modport master (
    output start, data_valid, data_in,
    input  busy, done, pass, signature, word_count
  );

  modport slave (
    input  start, data_valid, data_in,
    output busy, done, pass, signature, word_count
  );
endinterface

// File: rtl/risc_misr_compactor.sv
// DFT response compactor: folds core result words into a MISR and
// compares the final signature with a golden value after NUM_WORDS.
module risc_misr_compactor #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] POLY      = 16'h1021,
  parameter logic [WIDTH-1:0] SEED      = 16'hFFFF,
  parameter int               NUM_WORDS = 8,
  parameter logic [WIDTH-1:0] GOLDEN    = 16'h0000
) (
  input logic                  clk,
  input logic                  rst,
  risc_misr_compactor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST = 16'(NUM_WORDS - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [WIDTH-1:0] r_sig;
  logic [15:0]      r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [WIDTH-1:0] w_sig_d;
  logic [15:0]      w_cnt_d;
  logic             w_pass_d;
  logic [WIDTH-1:0] w_fb;
  logic             w_last;

  assign w_fb = {r_sig[WIDTH-2:0], 1'b0}
              ^ (r_sig[WIDTH-1] ? POLY : '0)
              ^ bus.data_in;

  assign w_last = bus.data_valid && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_sig   <= w_sig_d;
      r_cnt   <= w_cnt_d;
      r_busy  <= (w_nxt == S_RUN);
      r_done  <= (w_nxt == S_DONE);
      r_pass  <= w_pass_d;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_nxt = S_RUN;
      S_RUN:   if (w_last)    w_nxt = S_DONE;
      S_DONE:  if (bus.start) w_nxt = S_RUN;
      default: w_nxt = S_IDLE;
    endcase
  end

  // pass is only ever set on the edge that finishes the run
  always_comb begin
    w_sig_d  = r_sig;
    w_cnt_d  = r_cnt;
    w_pass_d = r_pass;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_sig_d  = SEED;
          w_cnt_d  = '0;
          w_pass_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.data_valid) begin
          w_sig_d = w_fb;
          w_cnt_d = r_cnt + 16'd1;
          if (w_last) w_pass_d = (w_fb == GOLDEN);
        end
      end
      default: begin
        w_sig_d  = SEED;
        w_cnt_d  = '0;
        w_pass_d = 1'b0;
      end
    endcase
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.signature  = r_sig;
  assign bus.word_count = r_cnt;

endmodule

// File: tb/tb_risc_misr_compactor.sv
// Scoreboarded bench for the MISR compactor: four instances with
// different seeds, lengths and golden values share one data stream.
module tb_risc_misr_compactor;

  typedef struct {
    logic [15:0] sig;
    logic [15:0] cnt;
    logic        pss;
  } exp_t;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED_T [4] =
    '{16'h0000, 16'h8000, 16'h8000, 16'hFFFF};
  localparam logic [15:0] GOLD_T [4] =
    '{16'h0000, 16'h0000, 16'h1021, 16'h0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic        dv = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] sig_a  [4];
  logic [15:0] cnt_a  [4];
  logic        busy_a [4];
  logic        done_a [4];
  logic        pass_a [4];
  logic        prev_d [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  risc_misr_compactor_if #(.WIDTH(16)) ifA ();
  risc_misr_compactor_if #(.WIDTH(16)) ifB ();
  risc_misr_compactor_if #(.WIDTH(16)) ifC ();
  risc_misr_compactor_if #(.WIDTH(16)) ifD ();

  risc_misr_compactor #(
    .WIDTH(16), .POLY(16'h1021), .SEED(16'h0000),
    .NUM_WORDS(2), .GOLDEN(16'h0000)
  ) dA (.clk(clk), .rst(rst), .bus(ifA));

  risc_misr_compactor #(
    .WIDTH(16), .POLY(16'h1021), .SEED(16'h8000),
    .NUM_WORDS(1), .GOLDEN(16'h0000)
  ) dB (.clk(clk), .rst(rst), .bus(ifB));

  risc_misr_compactor #(
    .WIDTH(16), .POLY(16'h1021), .SEED(16'h8000),
    .NUM_WORDS(1), .GOLDEN(16'h1021)
  ) dC (.clk(clk), .rst(rst), .bus(ifC));

  risc_misr_compactor #(
    .WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF),
    .NUM_WORDS(8), .GOLDEN(16'h0000)
  ) dD (.clk(clk), .rst(rst), .bus(ifD));

  assign ifA.start = st[0];
  assign ifB.start = st[1];
  assign ifC.start = st[2];
  assign ifD.start = st[3];
  assign ifA.data_valid = dv;
  assign ifB.data_valid = dv;
  assign ifC.data_valid = dv;
  assign ifD.data_valid = dv;
  assign ifA.data_in = din;
  assign ifB.data_in = din;
  assign ifC.data_in = din;
  assign ifD.data_in = din;

  assign sig_a[0] = ifA.signature;
  assign sig_a[1] = ifB.signature;
  assign sig_a[2] = ifC.signature;
  assign sig_a[3] = ifD.signature;
  assign cnt_a[0] = ifA.word_count;
  assign cnt_a[1] = ifB.word_count;
  assign cnt_a[2] = ifC.word_count;
  assign cnt_a[3] = ifD.word_count;
  assign busy_a[0] = ifA.busy;
  assign busy_a[1] = ifB.busy;
  assign busy_a[2] = ifC.busy;
  assign busy_a[3] = ifD.busy;
  assign done_a[0] = ifA.done;
  assign done_a[1] = ifB.done;
  assign done_a[2] = ifC.done;
  assign done_a[3] = ifD.done;
  assign pass_a[0] = ifA.pass;
  assign pass_a[1] = ifB.pass;
  assign pass_a[2] = ifC.pass;
  assign pass_a[3] = ifD.pass;

  // Multiply by x modulo the feedback polynomial, then add the word
  function automatic logic [15:0] misr(
    input logic [15:0] s, input logic [15:0] d
  );
    logic [16:0] p;
    p = {s, 1'b0};
    if (p[16]) p = p ^ {1'b1, POLY};
    return p[15:0] ^ d;
  endfunction

  function automatic logic [15:0] fold(
    input logic [15:0] seed, input logic [15:0] w[$]
  );
    logic [15:0] s;
    s = seed;
    foreach (w[k]) s = misr(s, w[k]);
    return s;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int id);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default:
        if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done dut=%0d actual=1 required=0", id);
    end else begin
      chk($sformatf("sb_sig%0d", id), 32'(sig_a[id]), 32'(e.sig));
      chk($sformatf("sb_cnt%0d", id), 32'(cnt_a[id]), 32'(e.cnt));
      chk($sformatf("sb_pass%0d", id), 32'(pass_a[id]), 32'(e.pss));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_a[i] && !prev_d[i]) pop_chk(i);
      prev_d[i] = done_a[i];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input int id, input logic [15:0] w[$],
    input int glo, input int ghi, input bit sp
  );
    exp_t e;
    int   g;
    e.sig = fold(SEED_T[id], w);
    e.cnt = 16'(w.size());
    e.pss = (e.sig == GOLD_T[id]);
    push(id, e);
    st[id] = 1'b1;
    dv = 1'b0;
    step;
    st[id] = 1'b0;
    for (int k = 0; k < w.size(); k++) begin
      dv = 1'b1;
      din = w[k];
      step;
      dv = 1'b0;
      din = 16'($urandom);
      if (k == 0)
        chk("first_sig", 32'(sig_a[id]), 32'(misr(SEED_T[id], w[0])));
      if (k != w.size() - 1) begin
        g = int'($urandom_range(ghi, glo));
        for (int j = 0; j < g; j++) begin
          if (sp && j == 0) st[id] = 1'b1;
          step;
          st[id] = 1'b0;
          chk("gap_busy", 32'(busy_a[id]), 32'd1);
        end
      end
    end
  endtask

  initial begin
    logic [15:0] wq[$];
    exp_t e;

    step;
    step;
    rst = 1'b0;
    step;
    chk("rst_sig", 32'(sig_a[3]), 32'hFFFF);
    chk("rst_cnt", 32'(cnt_a[3]), 32'd0);
    chk("rst_busy", 32'(busy_a[3]), 32'd0);
    chk("rst_done", 32'(done_a[3]), 32'd0);
    chk("rst_pass", 32'(pass_a[3]), 32'd0);

    wq = {};
    wq.push_back(16'h0001);
    wq.push_back(16'h0000);
    run(0, wq, 0, 0, 1'b0);
    chk("basic_sig", 32'(sig_a[0]), 32'h0002);
    chk("basic_done", 32'(done_a[0]), 32'd1);

    wq = {};
    wq.push_back(16'h0000);
    run(1, wq, 0, 0, 1'b0);
    chk("fb_sig", 32'(sig_a[1]), 32'h1021);
    chk("fb_pass0", 32'(pass_a[1]), 32'd0);
    run(2, wq, 0, 0, 1'b0);
    chk("fb_pass1", 32'(pass_a[2]), 32'd1);

    wq = {};
    wq.push_back(16'h0001);
    wq.push_back(16'h0000);
    run(0, wq, 3, 3, 1'b1);
    chk("gap_sig", 32'(sig_a[0]), 32'h0002);

    e.sig = 16'h1021;
    e.cnt = 16'd1;
    e.pss = 1'b1;
    push(2, e);
    st[2] = 1'b1;
    step;
    st[2] = 1'b0;
    chk("rs_done", 32'(done_a[2]), 32'd0);
    chk("rs_pass", 32'(pass_a[2]), 32'd0);
    chk("rs_busy", 32'(busy_a[2]), 32'd1);
    chk("rs_sig", 32'(sig_a[2]), 32'h8000);
    chk("rs_cnt", 32'(cnt_a[2]), 32'd0);
    dv = 1'b1;
    din = 16'h0000;
    step;
    dv = 1'b0;

    st[3] = 1'b1;
    step;
    st[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dv = 1'b1;
      din = 16'($urandom);
      step;
    end
    dv = 1'b0;
    chk("ab_cnt3", 32'(cnt_a[3]), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ab_sig", 32'(sig_a[3]), 32'hFFFF);
    chk("ab_cnt", 32'(cnt_a[3]), 32'd0);
    chk("ab_busy", 32'(busy_a[3]), 32'd0);
    chk("ab_done", 32'(done_a[3]), 32'd0);
    step;
    step;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dv = k[0];
      din = 16'($urandom);
      step;
    end
    dv = 1'b0;
    chk("idle_sig", 32'(sig_a[3]), 32'hFFFF);
    chk("idle_cnt", 32'(cnt_a[3]), 32'd0);
    chk("idle_busy", 32'(busy_a[3]), 32'd0);

    for (int r = 0; r < 6; r++) begin
      wq = {};
      for (int k = 0; k < 8; k++) wq.push_back(16'($urandom));
      run(3, wq, 0, 2, 1'b1);
      repeat (int'($urandom_range(2, 0))) step;
    end

    step;
    step;
    chk("drain",
        32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
